// File: rtl/riscv_pkg.sv
// Shared RV32I load/store encodings and the MEM-stage LSU state type.
package riscv_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } lsu_state_t;

  // Legal size/sign for the direction and naturally aligned for the size.
  function automatic logic access_ok(input logic is_load, input logic [2:0] f3,
                                     input logic [1:0] a);
    logic ok;
    case (f3)
      F3_B:    ok = 1'b1;
      F3_H:    ok = ~a[0];
      F3_W:    ok = (a == 2'b00);
      F3_BU:   ok = is_load;
      F3_HU:   ok = is_load & ~a[0];
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Picks the addressed byte/half out of a raw read word and sign/zero extends it.
module lsu_load_align
  import riscv_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  addr_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] result_o
);

  logic [31:0] bsh, hsh;
  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    bsh = rdata_i >> {addr_i, 3'b000};
    hsh = rdata_i >> {addr_i[1], 4'b0000};
    b   = bsh[7:0];
    h   = hsh[15:0];
    case (funct3_i)
      F3_B:    result_o = {{24{b[7]}}, b};
      F3_H:    result_o = {{16{h[15]}}, h};
      F3_W:    result_o = rdata_i;
      F3_BU:   result_o = {24'h0, b};
      F3_HU:   result_o = {16'h0, h};
      default: result_o = 32'h0;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: turns a load/store into a valid/ready memory request,
// stalls the pipeline until it completes and hands formatted load data to MEM/WB.
module mem_stage_lsu
  import riscv_pkg::*;
#(
  parameter int unsigned TIMEOUT = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memread_mem,
  input  logic        memwrite_mem,
  input  logic [2:0]  funct3_mem,
  input  logic [31:0] aluout_mem,
  input  logic [31:0] storedata_mem,
  output logic        req_valid,
  input  logic        req_ready,
  output logic        req_we,
  output logic [31:0] req_addr,
  output logic [31:0] req_wdata,
  output logic [3:0]  req_wstrb,
  input  logic        rsp_valid,
  input  logic [31:0] rsp_rdata,
  output logic [31:0] memdata_mem,
  output logic        stall_mem,
  output logic        fault_mem
);

  lsu_state_t  state_q, state_d;
  logic        req_valid_q, req_valid_d;
  logic        req_we_q, req_we_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic [31:0] req_wdata_q, req_wdata_d;
  logic [3:0]  req_wstrb_q, req_wstrb_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  off_q, off_d;
  logic [31:0] memdata_q, memdata_d;
  logic        fault_q, fault_d;

  logic        op, ok, timeout_hit;
  logic [31:0] st_wdata, ld_data;
  logic [3:0]  st_wstrb;

  assign op = memread_mem | memwrite_mem;
  assign ok = access_ok(memread_mem, funct3_mem, aluout_mem[1:0]);

  // Store data replicated into every lane so memory only has to honour the strobes.
  always_comb begin
    st_wdata = storedata_mem;
    st_wstrb = 4'b1111;
    case (funct3_mem[1:0])
      2'b00: begin
        st_wdata = {4{storedata_mem[7:0]}};
        st_wstrb = 4'b0001 << aluout_mem[1:0];
      end
      2'b01: begin
        st_wdata = {2{storedata_mem[15:0]}};
        st_wstrb = aluout_mem[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
    if (memread_mem) st_wstrb = 4'b0000;
  end

  lsu_load_align u_align (
    .rdata_i  (rsp_rdata),
    .addr_i   (off_q),
    .funct3_i (f3_q),
    .result_o (ld_data)
  );

  generate
    if (TIMEOUT != 0) begin : g_timeout
      localparam int CW = $clog2(TIMEOUT + 1);
      logic [CW-1:0] cnt_q;
      always_ff @(posedge clk or negedge rst) begin
        if (!rst)                   cnt_q <= '0;
        else if (state_q != S_WAIT) cnt_q <= '0;
        else                        cnt_q <= cnt_q + CW'(1);
      end
      assign timeout_hit = (cnt_q == CW'(TIMEOUT - 1));
    end else begin : g_no_timeout
      assign timeout_hit = 1'b0;
    end
  endgenerate

  always_comb begin
    state_d     = state_q;
    req_valid_d = req_valid_q;
    req_we_d    = req_we_q;
    req_addr_d  = req_addr_q;
    req_wdata_d = req_wdata_q;
    req_wstrb_d = req_wstrb_q;
    f3_d        = f3_q;
    off_d       = off_q;
    memdata_d   = memdata_q;
    fault_d     = fault_q;
    case (state_q)
      S_IDLE: if (op) begin
        if (!ok) begin
          state_d   = S_DONE;
          fault_d   = 1'b1;
          memdata_d = 32'h0;
        end else begin
          state_d     = S_REQ;
          req_valid_d = 1'b1;
          req_we_d    = memwrite_mem;
          req_addr_d  = {aluout_mem[31:2], 2'b00};
          req_wdata_d = st_wdata;
          req_wstrb_d = st_wstrb;
          f3_d        = funct3_mem;
          off_d       = aluout_mem[1:0];
        end
      end
      S_REQ: if (req_ready) begin
        req_valid_d = 1'b0;
        state_d     = req_we_q ? S_DONE : S_WAIT;
      end
      S_WAIT: begin
        if (rsp_valid) begin
          memdata_d = ld_data;
          fault_d   = 1'b0;
          state_d   = S_DONE;
        end else if (timeout_hit) begin
          memdata_d = 32'h0;
          fault_d   = 1'b1;
          state_d   = S_DONE;
        end
      end
      S_DONE: begin
        state_d   = S_IDLE;
        memdata_d = 32'h0;
        fault_d   = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      req_valid_q <= 1'b0;
      req_we_q    <= 1'b0;
      req_addr_q  <= 32'h0;
      req_wdata_q <= 32'h0;
      req_wstrb_q <= 4'h0;
      f3_q        <= 3'h0;
      off_q       <= 2'h0;
      memdata_q   <= 32'h0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_valid_q <= req_valid_d;
      req_we_q    <= req_we_d;
      req_addr_q  <= req_addr_d;
      req_wdata_q <= req_wdata_d;
      req_wstrb_q <= req_wstrb_d;
      f3_q        <= f3_d;
      off_q       <= off_d;
      memdata_q   <= memdata_d;
      fault_q     <= fault_d;
    end
  end

  assign stall_mem   = op & (state_q != S_DONE);
  assign req_valid   = req_valid_q;
  assign req_we      = req_we_q;
  assign req_addr    = req_addr_q;
  assign req_wdata   = req_wdata_q;
  assign req_wstrb   = req_wstrb_q;
  assign memdata_mem = memdata_q;
  assign fault_mem   = fault_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench: the driver queues expected requests/results, a negedge monitor checks them.
module tb_mem_stage_lsu;
  import riscv_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic memread, memwrite;
  logic [2:0]  funct3;
  logic [31:0] addr, sdata;
  logic req_ready, rsp_valid;
  logic [31:0] rsp_rdata;
  logic req_valid, req_we, stall_mem, fault_mem;
  logic [31:0] req_addr, req_wdata, memdata_mem;
  logic [3:0]  req_wstrb;

  logic memread2, rdy2, rsv2;
  logic req_valid2, req_we2, stall2, fault2;
  logic [31:0] req_addr2, req_wdata2, memdata2;
  logic [3:0]  req_wstrb2;

  always #5 clk = ~clk;

  mem_stage_lsu dut (
    .clk(clk), .rst(rst), .memread_mem(memread), .memwrite_mem(memwrite),
    .funct3_mem(funct3), .aluout_mem(addr), .storedata_mem(sdata),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wstrb(req_wstrb), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .memdata_mem(memdata_mem), .stall_mem(stall_mem), .fault_mem(fault_mem)
  );

  mem_stage_lsu #(.TIMEOUT(4)) dut_to (
    .clk(clk), .rst(rst), .memread_mem(memread2), .memwrite_mem(1'b0),
    .funct3_mem(funct3), .aluout_mem(addr), .storedata_mem(sdata),
    .req_valid(req_valid2), .req_ready(rdy2), .req_we(req_we2), .req_addr(req_addr2),
    .req_wdata(req_wdata2), .req_wstrb(req_wstrb2), .rsp_valid(rsv2), .rsp_rdata(rsp_rdata),
    .memdata_mem(memdata2), .stall_mem(stall2), .fault_mem(fault2)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } exp_req_t;

  typedef struct packed {
    logic [31:0] memdata;
    logic        fault;
  } exp_rsp_t;

  exp_req_t req_q[$];
  exp_rsp_t rsp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_req_t er;
    exp_rsp_t es;
    if (rst) begin
      if (req_valid && req_ready) begin
        if (req_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_req act=%h exp=none", req_addr);
        end else begin
          er = req_q.pop_front();
          check("req_addr", req_addr, er.addr);
          check("req_we", {31'b0, req_we}, {31'b0, er.we});
          if (er.we) begin
            check("req_wdata", req_wdata, er.wdata);
            check("req_wstrb", {28'b0, req_wstrb}, {28'b0, er.wstrb});
          end
        end
      end
      if ((memread || memwrite) && !stall_mem) begin
        if (rsp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done act=%h exp=none", memdata_mem);
        end else begin
          es = rsp_q.pop_front();
          check("memdata", memdata_mem, es.memdata);
          check("fault", {31'b0, fault_mem}, {31'b0, es.fault});
        end
      end
    end
  end

  // Called at posedge+1 with the LSU idle; returns at posedge+1 with the LSU idle again.
  task automatic run_op(input string nm, input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] d, input logic [31:0] rdata,
                        input int rdy_wait, input int rsp_wait, input bit bad,
                        input logic [31:0] e_addr, input logic [31:0] e_wdata,
                        input logic [3:0] e_wstrb, input logic [31:0] e_mem,
                        input logic e_fault, input int e_stalls);
    int stalls = 0;
    int cyc = 0;
    int rw = rdy_wait;
    int sw = rsp_wait;
    bit acc = 0;
    bit wait_st = 0;
    if (!bad) req_q.push_back('{addr: e_addr, we: wr, wdata: e_wdata, wstrb: e_wstrb});
    rsp_q.push_back('{memdata: e_mem, fault: e_fault});
    memread = rd; memwrite = wr; funct3 = f3; addr = a; sdata = d;
    req_ready = 1'b0; rsp_valid = 1'b0;
    #1;
    while (stall_mem && cyc < 60) begin
      stalls++;
      if (bad) check({nm, "_no_req"}, {31'b0, req_valid}, 32'h0);
      if (acc) wait_st = 1;
      if (!wait_st) begin
        if (req_valid && rw > 0) begin
          check({nm, "_hold_addr"}, req_addr, e_addr);
          if (wr) check({nm, "_hold_wdata"}, req_wdata, e_wdata);
          req_ready = 1'b0;
          rw--;
        end else if (req_valid) begin
          req_ready = 1'b1;
          acc = 1;
        end else req_ready = 1'b0;
      end else begin
        req_ready = 1'b0;
        if (sw > 0) begin rsp_valid = 1'b0; sw--; end
        else begin rsp_valid = 1'b1; rsp_rdata = rdata; end
      end
      @(posedge clk); #1;
      cyc++;
    end
    req_ready = 1'b0; rsp_valid = 1'b0;
    if (stall_mem) begin
      checks++; errors++;
      $display("FAIL %s_done_timeout act=stalled exp=done", nm);
    end
    check({nm, "_stalls"}, stalls, e_stalls);
    @(posedge clk); #1;
    memread = 1'b0; memwrite = 1'b0;
  endtask

  initial begin
    int st;
    int cyc;
    rst = 1'b0; memread = 0; memwrite = 0; funct3 = 0; addr = 0; sdata = 0;
    req_ready = 0; rsp_valid = 0; rsp_rdata = 0; memread2 = 0; rdy2 = 0; rsv2 = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_valid", {31'b0, req_valid}, 32'h0);
    check("rst_req_addr", req_addr, 32'h0);
    check("rst_memdata", memdata_mem, 32'h0);
    check("rst_fault", {31'b0, fault_mem}, 32'h0);
    rst = 1'b1;
    @(posedge clk); #1;

    //     name  rd wr f3     addr         sdata         rdata        rdy rsp bad e_addr       e_wdata       strb  e_mem         flt stl
    run_op("sw",  0, 1, F3_W, 32'h100, 32'hDEADBEEF, 32'h0,        0, 0, 0, 32'h100, 32'hDEADBEEF, 4'hF, 32'h0,        0, 2);
    run_op("sb",  0, 1, F3_B, 32'h103, 32'h000000A5, 32'h0,        0, 0, 0, 32'h100, 32'hA5A5A5A5, 4'h8, 32'h0,        0, 2);
    run_op("sh",  0, 1, F3_H, 32'h102, 32'h1234CAFE, 32'h0,        0, 0, 0, 32'h100, 32'hCAFECAFE, 4'hC, 32'h0,        0, 2);
    run_op("lb",  1, 0, F3_B, 32'h101, 32'h0,        32'h00008000, 0, 0, 0, 32'h100, 32'h0,        4'h0, 32'hFFFFFF80, 0, 3);
    run_op("lbu", 1, 0, F3_BU,32'h101, 32'h0,        32'h00008000, 0, 0, 0, 32'h100, 32'h0,        4'h0, 32'h00000080, 0, 3);
    run_op("lhu", 1, 0, F3_HU,32'h102, 32'h0,        32'hBEEF1234, 0, 5, 0, 32'h100, 32'h0,        4'h0, 32'h0000BEEF, 0, 8);
    run_op("lh",  1, 0, F3_H, 32'h102, 32'h0,        32'h80011234, 0, 0, 0, 32'h100, 32'h0,        4'h0, 32'hFFFF8001, 0, 3);
    run_op("lwmis",1,0, F3_W, 32'h102, 32'h0,        32'h0,        0, 0, 1, 32'h0,   32'h0,        4'h0, 32'h0,        1, 1);
    run_op("ld011",1,0, 3'b011,32'h100,32'h0,        32'h0,        0, 0, 1, 32'h0,   32'h0,        4'h0, 32'h0,        1, 1);
    run_op("sw_rdy",0,1,F3_W, 32'h104, 32'h0BADF00D, 32'h0,        3, 0, 0, 32'h104, 32'h0BADF00D, 4'hF, 32'h0,        0, 5);
    run_op("sbu", 0, 1, F3_BU,32'h100, 32'h11,       32'h0,        0, 0, 1, 32'h0,   32'h0,        4'h0, 32'h0,        1, 1);

    // Reset while a load sits in WAIT, then a stray response must be ignored.
    req_q.push_back('{addr: 32'h300, we: 1'b0, wdata: 32'h0, wstrb: 4'h0});
    memread = 1'b1; funct3 = F3_W; addr = 32'h300;
    #1;
    repeat (4) begin
      req_ready = req_valid;
      @(posedge clk); #1;
    end
    req_ready = 1'b0;
    check("wait_stall", {31'b0, stall_mem}, 32'h1);
    rst = 1'b0; memread = 1'b0;
    #1;
    check("rstw_req_valid", {31'b0, req_valid}, 32'h0);
    check("rstw_req_addr", req_addr, 32'h0);
    check("rstw_req_wdata", req_wdata, 32'h0);
    check("rstw_stall", {31'b0, stall_mem}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rsp_valid = 1'b1; rsp_rdata = 32'hFFFFFFFF;
    @(posedge clk); #1;
    rsp_valid = 1'b0;
    check("stray_memdata", memdata_mem, 32'h0);
    check("stray_fault", {31'b0, fault_mem}, 32'h0);
    check("stray_req_valid", {31'b0, req_valid}, 32'h0);
    @(posedge clk); #1;

    run_op("lw",  1, 0, F3_W, 32'h108, 32'h0,        32'h11223344, 0, 0, 0, 32'h108, 32'h0,        4'h0, 32'h11223344, 0, 3);

    // Timeout instance: load with no response gives up after four WAIT cycles.
    memread2 = 1'b1; funct3 = F3_W; addr = 32'h200;
    #1;
    st = 0; cyc = 0;
    while (stall2 && cyc < 60) begin
      st++;
      rdy2 = req_valid2;
      @(posedge clk); #1;
      cyc++;
    end
    rdy2 = 1'b0;
    check("to_stalls", st, 6);
    check("to_fault", {31'b0, fault2}, 32'h1);
    check("to_memdata", memdata2, 32'h0);
    @(posedge clk); #1;
    memread2 = 1'b0;
    check("to_cleared", {31'b0, fault2}, 32'h0);

    repeat (2) @(posedge clk);
    if (req_q.size() != 0 || rsp_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL leftover act=%0d exp=0", req_q.size() + rsp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
